// File: rtl/keypad_scanner_pkg.sv
// Shared keypad/FND definitions: debouncer state encoding, per-frame scan
// result encoding and the active-low one-hot column/digit drive patterns.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESS_DEB = 2'd1,
    ST_HELD      = 2'd2,
    ST_REL_DEB   = 2'd3
  } deb_state_t;

  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_result_t;

  // Active-low one-hot drive patterns, identical to the FND digit select.
  localparam logic [3:0] COL0_N = 4'b1110;
  localparam logic [3:0] COL1_N = 4'b1101;
  localparam logic [3:0] COL2_N = 4'b1011;
  localparam logic [3:0] COL3_N = 4'b0111;

  function automatic logic [3:0] col_drive_n(input logic [1:0] idx);
    logic [3:0] pat;
    case (idx)
      2'd0:    pat = COL0_N;
      2'd1:    pat = COL1_N;
      2'd2:    pat = COL2_N;
      default: pat = COL3_N;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// Frame-level press/release debouncer. Consumes one scan result per frame
// and turns it into a held key code, a one-cycle press strobe and a level.
//
// Frame interface: i_frame_done is a single-cycle strobe with no back-pressure;
// i_frame_result and i_frame_code are meaningful only in the cycle where
// i_frame_done is high and are ignored otherwise.
module keypad_debouncer
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_done,
  input  logic [1:0] i_frame_result,
  input  logic [3:0] i_frame_code,
  output logic [3:0] o_key_code,
  output logic       o_key_valid,
  output logic       o_key_pressed,
  output logic [1:0] o_state
);

  localparam int CNT_W = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  deb_state_t       r_state;
  deb_state_t       w_next_state;
  logic [3:0]       r_cand;
  logic [3:0]       w_next_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_accept;
  logic             w_release;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_pressed;

  assign w_cnt_inc = r_cnt + CNT_ONE;

  // Next-state logic; decisions are taken only on the frame-end strobe.
  always_comb begin
    w_next_state = r_state;
    w_next_cand  = r_cand;
    w_next_cnt   = r_cnt;
    w_accept     = 1'b0;
    w_release    = 1'b0;
    if (i_frame_done) begin
      case (r_state)
        ST_IDLE: begin
          if (i_frame_result == FR_SINGLE) begin
            w_next_cand = i_frame_code;
            if (CNT_ONE >= DEB_TARGET) begin
              w_accept     = 1'b1;
              w_next_state = ST_HELD;
              w_next_cnt   = '0;
            end else begin
              w_next_state = ST_PRESS_DEB;
              w_next_cnt   = CNT_ONE;
            end
          end
        end
        ST_PRESS_DEB: begin
          if (i_frame_result == FR_SINGLE) begin
            if (i_frame_code == r_cand) begin
              if (w_cnt_inc >= DEB_TARGET) begin
                w_accept     = 1'b1;
                w_next_state = ST_HELD;
                w_next_cnt   = '0;
              end else begin
                w_next_cnt = w_cnt_inc;
              end
            end else begin
              // A different single key restarts the count on the new key.
              w_next_cand = i_frame_code;
              w_next_cnt  = CNT_ONE;
            end
          end else begin
            w_next_state = ST_IDLE;
            w_next_cnt   = '0;
          end
        end
        ST_HELD: begin
          // Any key activity keeps the hold; there is no rollover.
          if (i_frame_result == FR_NONE) begin
            if (CNT_ONE >= DEB_TARGET) begin
              w_release    = 1'b1;
              w_next_state = ST_IDLE;
              w_next_cnt   = '0;
            end else begin
              w_next_state = ST_REL_DEB;
              w_next_cnt   = CNT_ONE;
            end
          end
        end
        ST_REL_DEB: begin
          if (i_frame_result == FR_NONE) begin
            if (w_cnt_inc >= DEB_TARGET) begin
              w_release    = 1'b1;
              w_next_state = ST_IDLE;
              w_next_cnt   = '0;
            end else begin
              w_next_cnt = w_cnt_inc;
            end
          end else begin
            w_next_state = ST_HELD;
            w_next_cnt   = '0;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  // State, candidate and debounce counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cand  <= 4'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cand  <= w_next_cand;
      r_cnt   <= w_next_cnt;
    end
  end

  // Output registers: code latched only on accept, strobe lasts one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_key_code    <= 4'd0;
      r_key_valid   <= 1'b0;
      r_key_pressed <= 1'b0;
    end else begin
      r_key_valid <= w_accept;
      if (w_accept) begin
        r_key_code    <= w_next_cand;
        r_key_pressed <= 1'b1;
      end else if (w_release) begin
        r_key_pressed <= 1'b0;
      end
    end
  end

  assign o_key_code    = r_key_code;
  assign o_key_valid   = r_key_valid;
  assign o_key_pressed = r_key_pressed;
  assign o_state       = r_state;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low column per slot, samples
// synchronized active-low rows at the end of each slot, folds the four
// samples of a frame into NONE/SINGLE/MULTI and hands that to the debouncer.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int CLK_FREQ       = 1_000,
  parameter int SCAN_HZ        = 50,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int COL_CNT = CLK_FREQ / (SCAN_HZ * 4);
  localparam int SLOT_W  = (COL_CNT <= 2) ? 1 : $clog2(COL_CNT);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(COL_CNT - 1);

  // The two synchronizer flops must settle inside one column slot.
  if (COL_CNT < 3) begin : g_bad_col_cnt
    $error("keypad_scanner: COL_CNT = CLK_FREQ/(SCAN_HZ*4) must be >= 3");
  end
  if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
    $error("keypad_scanner: DEBOUNCE_SCANS must be >= 1");
  end

  logic [3:0]        r_sync1;
  logic [3:0]        r_sync2;
  logic [SLOT_W-1:0] r_slot;
  logic [1:0]        r_col_idx;
  logic [3:0]        r_col_n;
  logic [1:0]        r_hits;
  logic [3:0]        r_first;

  logic              w_sample;
  logic              w_frame_done;
  logic [3:0]        w_row_low;
  logic              w_any;
  logic              w_two;
  logic [1:0]        w_col_hits;
  logic [1:0]        w_first_row;
  logic [2:0]        w_sum;
  logic [1:0]        w_hits_total;
  logic [3:0]        w_first_code;
  frame_result_t     w_frame_result;
  logic [1:0]        w_deb_state;

  assign w_sample     = (r_slot == SLOT_LAST);
  assign w_frame_done = w_sample && (r_col_idx == 2'd3);
  assign w_row_low    = ~r_sync2;
  assign w_any        = |w_row_low;
  assign w_two        = (w_row_low & (w_row_low - 4'd1)) != 4'd0;
  assign w_col_hits   = w_two ? 2'd2 : (w_any ? 2'd1 : 2'd0);
  assign col_n        = r_col_n;

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= row_n;
      r_sync2 <= r_sync1;
    end
  end

  // Slot counter and column rotation; col_n is registered to stay glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot    <= '0;
      r_col_idx <= 2'd0;
      r_col_n   <= COL0_N;
    end else if (w_sample) begin
      r_slot    <= '0;
      r_col_idx <= r_col_idx + 2'd1;
      r_col_n   <= col_drive_n(r_col_idx + 2'd1);
    end else begin
      r_slot <= r_slot + SLOT_W'(1);
    end
  end

  // Lowest low row of the current sample, and the frame totals including it.
  always_comb begin
    w_first_row = 2'd0;
    if (w_row_low[0])      w_first_row = 2'd0;
    else if (w_row_low[1]) w_first_row = 2'd1;
    else if (w_row_low[2]) w_first_row = 2'd2;
    else if (w_row_low[3]) w_first_row = 2'd3;
    w_sum        = {1'b0, r_hits} + {1'b0, w_col_hits};
    w_hits_total = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    w_first_code = r_first;
    if ((r_hits == 2'd0) && w_any) begin
      w_first_code = {r_col_idx, w_first_row};
    end
    w_frame_result = FR_NONE;
    if (w_hits_total == 2'd1)      w_frame_result = FR_SINGLE;
    else if (w_hits_total >= 2'd2) w_frame_result = FR_MULTI;
  end

  // Frame accumulator; cleared on the column-3 sample that closes the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hits  <= 2'd0;
      r_first <= 4'd0;
    end else if (w_sample) begin
      if (r_col_idx == 2'd3) begin
        r_hits  <= 2'd0;
        r_first <= 4'd0;
      end else begin
        r_hits  <= w_hits_total;
        r_first <= w_first_code;
      end
    end
  end

  keypad_debouncer #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debouncer (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_frame_done  (w_frame_done),
    .i_frame_result(w_frame_result),
    .i_frame_code  (w_first_code),
    .o_key_code    (key_code),
    .o_key_valid   (key_valid),
    .o_key_pressed (key_pressed),
    .o_state       (w_deb_state)
  );

  // The pressed level is exactly the HELD/REL_DEB part of the state space.
  a_pressed_matches_state : assert property (@(posedge clk) disable iff (rst)
    key_pressed == ((w_deb_state == ST_HELD) || (w_deb_state == ST_REL_DEB)));

endmodule
